// File: rtl/des_pkg.sv
// des_pkg: shared DES constants and types.
//   DES_BLK_W / DES_HALF_W : block and half-block widths.
//   FP  : inverse initial permutation. Output DES bit i = input DES bit FP[i-1].
//   IP  : initial permutation, used by the entry stage.
//   PC1 : permuted choice 1, used by the entry-stage key path.
//   buf_state_e : occupancy states of the 2-entry output buffer.
// DES bit numbering is 1-based from the MSB: DES bit n of a W-bit vector is index W-n.
package des_pkg;

  localparam int unsigned DES_BLK_W  = 64;
  localparam int unsigned DES_HALF_W = 32;
  localparam int unsigned DES_PC1_W  = 56;

  localparam int unsigned FP [DES_BLK_W] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

  localparam int unsigned IP [DES_BLK_W] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int unsigned PC1 [DES_PC1_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/des_fp_buf.sv
// des_fp_buf: 2-entry valid/ready buffer for the final-permutation stage.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_data/in_valid      : payload offered by the producer
//   in_ready              : registered, low only when both entries are occupied
//   out_data/out_valid    : entry at the read pointer, held while not accepted
//   out_ready             : consumer accepts out_data
// in_ready and out_valid are decoded from the next state and registered, so
// neither depends combinationally on the opposite handshake.
module des_fp_buf
  import des_pkg::*;
#(
  parameter int unsigned W = 68
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  buf_state_e   state;
  logic         wp;
  logic         rp;
  logic [W-1:0] mem [2];
  logic         acc;
  logic         dlv;

  assign acc      = in_valid & in_ready;
  assign dlv      = out_valid & out_ready;
  assign out_data = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BUF_EMPTY;
      wp        <= 1'b0;
      rp        <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mem[0]    <= '0;
      mem[1]    <= '0;
    end else begin
      // Entries are written only on accept, so idle-cycle X never reaches storage.
      if (acc) begin
        mem[wp] <= in_data;
        wp      <= ~wp;
      end
      if (dlv) begin
        rp <= ~rp;
      end
      case (state)
        BUF_EMPTY: begin
          if (acc) begin
            state     <= BUF_ONE;
            out_valid <= 1'b1;
          end
        end
        BUF_ONE: begin
          if (acc && !dlv) begin
            state    <= BUF_FULL;
            in_ready <= 1'b0;
          end else if (!acc && dlv) begin
            state     <= BUF_EMPTY;
            out_valid <= 1'b0;
          end
        end
        BUF_FULL: begin
          if (dlv) begin
            state    <= BUF_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= BUF_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/des_final_perm.sv
// des_final_perm: DES output stage. Swaps the round-16 halves (preoutput =
// R16 || L16), applies IP^-1 and returns the block through a 2-entry buffer.
//   clk, rst_n              : clock, asynchronous active-low reset
//   l16, r16                : round-16 halves, DES bits [32:1] at indices [31:0]
//   in_tag                  : sideband tag travelling with the block
//   in_valid / in_ready     : input handshake
//   data_out, out_tag       : permuted block and its tag
//   out_valid / out_ready   : output handshake
//   blk_cnt                 : wrapping count of delivered blocks
module des_final_perm
  import des_pkg::*;
#(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DES_HALF_W-1:0] l16,
  input  logic [DES_HALF_W-1:0] r16,
  input  logic [TAG_W-1:0]      in_tag,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DES_BLK_W-1:0]  data_out,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      blk_cnt
);

  localparam int unsigned PAY_W = DES_BLK_W + TAG_W;

  logic [DES_BLK_W-1:0] pre_out;
  logic [DES_BLK_W-1:0] perm;
  logic [PAY_W-1:0]     buf_out;

  assign pre_out = {r16, l16};

  // Output DES bit g+1 sits at index 63-g; its source DES bit FP[g] sits at 64-FP[g].
  for (genvar g = 0; g < DES_BLK_W; g++) begin : g_fp
    localparam int unsigned SRC = DES_BLK_W - FP[g];
    assign perm[DES_BLK_W-1-g] = pre_out[SRC];
  end

  des_fp_buf #(
    .W (PAY_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({in_tag, perm}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (buf_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign {out_tag, data_out} = buf_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= '0;
    end else if (out_valid && out_ready) begin
      blk_cnt <= blk_cnt + CNT_W'(1);
    end
  end

endmodule
